// File: rtl/compare_flag_decoder.sv
// compare_flag_decoder: receives 2-bit magnitude-compare flag codes
// (01 gt, 10 eq, 11 lt, 00 no-op/invalid) over valid/ready, decodes them to
// registered one-hot less/equal/greater, keeps saturating per-outcome counters
// and runs a lock FSM that asserts after LOCK_N consecutive "equal" codes.
//
// Optional feature macro: CMP_DEC_STICKY_ERR_EN
//   defined   : err is sticky until clear/rst and stalls the stream (ready=0)
//   undefined : err is a one-cycle pulse after each accepted 00
module compare_flag_decoder #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             flag_valid,
    input  logic [1:0]       flag,
    output logic             flag_ready,
    output logic             less,
    output logic             equal,
    output logic             greater,
    output logic             err,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] gt_count,
    output logic             locked
);

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StLocked
    } state_e;

    localparam logic [1:0]       FlagNop = 2'b00;
    localparam logic [1:0]       FlagGt  = 2'b01;
    localparam logic [1:0]       FlagEq  = 2'b10;
    localparam logic [1:0]       FlagLt  = 2'b11;
    localparam logic [7:0]       LockN   = 8'(LOCK_N);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    state_e     state;
    logic [7:0] run;
    logic       rdy_en;   // goes high on the first edge after reset releases
    logic       accept;
    logic       run_hits; // this "equal" completes the required run

    // Ready gating: blocked during reset, clear and (when sticky) a held error
    always_comb begin
`ifdef CMP_DEC_STICKY_ERR_EN
        flag_ready = rdy_en & ~clear & ~rst & ~err;
`else
        flag_ready = rdy_en & ~clear & ~rst;
`endif
        accept   = flag_valid & flag_ready;
        run_hits = ({1'b0, run} + 9'd1) >= {1'b0, LockN};
    end

    // Decode, counters, run tracking and lock FSM, all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en   <= 1'b0;
            state    <= StIdle;
            run      <= 8'd0;
            less     <= 1'b0;
            equal    <= 1'b0;
            greater  <= 1'b0;
            err      <= 1'b0;
            lt_count <= '0;
            eq_count <= '0;
            gt_count <= '0;
            locked   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (clear) begin
                state    <= StIdle;
                run      <= 8'd0;
                less     <= 1'b0;
                equal    <= 1'b0;
                greater  <= 1'b0;
                err      <= 1'b0;
                lt_count <= '0;
                eq_count <= '0;
                gt_count <= '0;
                locked   <= 1'b0;
            end else begin
`ifndef CMP_DEC_STICKY_ERR_EN
                // Pulse mode: err only survives the cycle right after a 00
                err <= 1'b0;
`endif
                if (accept) begin
                    less    <= (flag == FlagLt);
                    equal   <= (flag == FlagEq);
                    greater <= (flag == FlagGt);
                    if (flag == FlagNop) begin
                        err <= 1'b1;
                    end
                    if (flag == FlagLt && lt_count != CntMax) begin
                        lt_count <= lt_count + CntOne;
                    end
                    if (flag == FlagEq && eq_count != CntMax) begin
                        eq_count <= eq_count + CntOne;
                    end
                    if (flag == FlagGt && gt_count != CntMax) begin
                        gt_count <= gt_count + CntOne;
                    end

                    // Every state reacts the same way: equal extends the run,
                    // anything else breaks it and falls back to tracking.
                    if (flag == FlagEq) begin
                        if (run != LockN) begin
                            run <= run + 8'd1;
                        end
                        if (run_hits) begin
                            state  <= StLocked;
                            locked <= 1'b1;
                        end else begin
                            state  <= StTrack;
                            locked <= 1'b0;
                        end
                    end else begin
                        run    <= 8'd0;
                        state  <= StTrack;
                        locked <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_flag_decoder.sv
// Directed self-checking bench for compare_flag_decoder. Main instance uses
// CNT_W=8/LOCK_N=4; a second instance (CNT_W=2/LOCK_N=1) covers counter
// saturation and single-equal locking. Expectations follow the
// CMP_DEC_STICKY_ERR_EN build setting.
module tb_compare_flag_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       flag_valid;
    logic [1:0] flag;
    logic       flag_ready;
    logic       less, equal, greater, err, locked;
    logic [7:0] lt_count, eq_count, gt_count;

    logic       flag_valid2;
    logic [1:0] flag2;
    logic       flag_ready2;
    logic       less2, equal2, greater2, err2, locked2;
    logic [1:0] lt_count2, eq_count2, gt_count2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    compare_flag_decoder #(.CNT_W(8), .LOCK_N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .flag_valid (flag_valid),
        .flag       (flag),
        .flag_ready (flag_ready),
        .less       (less),
        .equal      (equal),
        .greater    (greater),
        .err        (err),
        .lt_count   (lt_count),
        .eq_count   (eq_count),
        .gt_count   (gt_count),
        .locked     (locked)
    );

    compare_flag_decoder #(.CNT_W(2), .LOCK_N(1)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .flag_valid (flag_valid2),
        .flag       (flag2),
        .flag_ready (flag_ready2),
        .less       (less2),
        .equal      (equal2),
        .greater    (greater2),
        .err        (err2),
        .lt_count   (lt_count2),
        .eq_count   (eq_count2),
        .gt_count   (gt_count2),
        .locked     (locked2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_onehot(input string tag, input logic l, input logic e, input logic g);
        chk({tag, ".less"}, 32'(less), 32'(l));
        chk({tag, ".equal"}, 32'(equal), 32'(e));
        chk({tag, ".greater"}, 32'(greater), 32'(g));
    endtask

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        flag_valid  = 1'b0;
        flag        = 2'b00;
        flag_valid2 = 1'b0;
        flag2       = 2'b00;

        // Reset state
        #3;
        chk("rst.ready", 32'(flag_ready), 0);
        chk_onehot("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.err", 32'(err), 0);
        chk("rst.locked", 32'(locked), 0);
        chk("rst.gt_count", 32'(gt_count), 0);
        step();
        step();
        rst = 1'b0;
        chk("rst_rel.ready", 32'(flag_ready), 0);
        step();
        chk("rst_rel.ready_edge", 32'(flag_ready), 1);

        // Decode stream 01,10,11,01 back-to-back
        flag_valid = 1'b1;
        flag = 2'b01; step(); chk_onehot("dec1", 1'b0, 1'b0, 1'b1);
        flag = 2'b10; step(); chk_onehot("dec2", 1'b0, 1'b1, 1'b0);
        flag = 2'b11; step(); chk_onehot("dec3", 1'b1, 1'b0, 1'b0);
        flag = 2'b01; step(); chk_onehot("dec4", 1'b0, 1'b0, 1'b1);
        flag_valid = 1'b0;
        chk("dec.gt_count", 32'(gt_count), 2);
        chk("dec.eq_count", 32'(eq_count), 1);
        chk("dec.lt_count", 32'(lt_count), 1);
        chk("dec.locked", 32'(locked), 0);
        step();
        chk_onehot("hold", 1'b0, 1'b0, 1'b1);
        chk("hold.gt_count", 32'(gt_count), 2);

        // Asynchronous reset pulse mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("arst.greater", 32'(greater), 0);
        chk("arst.gt_count", 32'(gt_count), 0);
        chk("arst.ready", 32'(flag_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("arst_rel.ready", 32'(flag_ready), 0);
        step();
        chk("arst_rel.ready_edge", 32'(flag_ready), 1);

        // Lock after four equals, then break with less
        flag_valid = 1'b1;
        flag = 2'b10;
        step(); chk("lock1", 32'(locked), 0);
        step(); chk("lock2", 32'(locked), 0);
        step(); chk("lock3", 32'(locked), 0);
        step(); chk("lock4", 32'(locked), 1);
        flag = 2'b11;
        step();
        chk("unlock.locked", 32'(locked), 0);
        chk("unlock.less", 32'(less), 1);
        chk("unlock.eq_count", 32'(eq_count), 4);
        flag = 2'b10;
        step(); chk("relock1", 32'(locked), 0);
        step(); chk("relock2", 32'(locked), 0);
        step(); chk("relock3", 32'(locked), 0);
        step(); chk("relock4", 32'(locked), 1);
        step(); chk("stay_locked", 32'(locked), 1);
        chk("stay.eq_count", 32'(eq_count), 9);

        // Invalid code drops lock, no counter changes
        flag = 2'b00;
        step();
        flag_valid = 1'b0;
        chk("nop.err", 32'(err), 1);
        chk("nop.locked", 32'(locked), 0);
        chk_onehot("nop", 1'b0, 1'b0, 1'b0);
        chk("nop.lt_count", 32'(lt_count), 1);
        chk("nop.eq_count", 32'(eq_count), 9);
        chk("nop.gt_count", 32'(gt_count), 0);
`ifdef CMP_DEC_STICKY_ERR_EN
        chk("nop.ready", 32'(flag_ready), 0);
        step();
        chk("nop.err_held", 32'(err), 1);
        chk("nop.ready_held", 32'(flag_ready), 0);
`else
        chk("nop.ready", 32'(flag_ready), 1);
        step();
        chk("nop.err_pulse", 32'(err), 0);
        chk("nop.ready_after", 32'(flag_ready), 1);
`endif
        clear = 1'b1;
        #1;
        chk("clr.ready", 32'(flag_ready), 0);
        step();
        clear = 1'b0;
        #1;
        chk("clr.err", 32'(err), 0);
        chk("clr.eq_count", 32'(eq_count), 0);
        chk("clr.lt_count", 32'(lt_count), 0);
        chk("clr.ready_after", 32'(flag_ready), 1);

        // Clear with valid present: no accept, run discarded
        flag_valid = 1'b1;
        flag = 2'b01; step();
        flag = 2'b10; step(); step();
        chk("pre_clr.gt_count", 32'(gt_count), 1);
        flag = 2'b01;
        clear = 1'b1;
        #1;
        chk("clrv.ready", 32'(flag_ready), 0);
        step();
        clear = 1'b0;
        flag_valid = 1'b0;
        #1;
        chk("clrv.gt_count", 32'(gt_count), 0);
        chk("clrv.greater", 32'(greater), 0);
        chk("clrv.eq_count", 32'(eq_count), 0);
        flag_valid = 1'b1;
        flag = 2'b10;
        step(); step(); step();
        chk("clrv.run_reset", 32'(locked), 0);
        step();
        chk("clrv.lock4", 32'(locked), 1);
        flag_valid = 1'b0;

        // Saturation with CNT_W=2, single-equal lock with LOCK_N=1
        flag_valid2 = 1'b1;
        flag2 = 2'b01;
        step(); chk("sat1", 32'(gt_count2), 1);
        step(); chk("sat2", 32'(gt_count2), 2);
        step(); chk("sat3", 32'(gt_count2), 3);
        step(); chk("sat4", 32'(gt_count2), 3);
        step(); chk("sat5", 32'(gt_count2), 3);
        flag2 = 2'b10;
        step();
        chk("n1.locked", 32'(locked2), 1);
        chk("n1.eq_count", 32'(eq_count2), 1);
        flag2 = 2'b01;
        step();
        chk("n1.unlock", 32'(locked2), 0);
        flag_valid2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
